param_sync_fifo: RTL and testbench

- Single-clock, first-word-fall-through (FWFT) FIFO of configurable width and depth, with full, empty and occupancy count.
- Used as the generic buffering primitive in AXI4 datapaths: stream stages, skid buffers and channel decoupling.
- D=2 is built from a dedicated two-register core; all other depths use a RAM array with read/write pointers.

---
 rtl/param_sync_fifo_pkg.sv | 21 ++
 rtl/param_sync_fifo_if.sv | 32 +++
 rtl/param_sync_fifo_2deep.sv | 92 +++++++++
 rtl/param_sync_fifo.sv | 96 +++++++++
 tb/tb_param_sync_fifo.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/param_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_pkg
// Shared types and helpers for the parameterised synchronous FWFT FIFO.
//   fifo2_state_e : state of the dedicated two-entry core. The encoding is
//                   {full, empty}, so both flags are plain register bits.
//   ptr_inc       : pointer increment that wraps from depth-1 back to 0.
// -----------------------------------------------------------------------------
package param_sync_fifo_pkg;

   typedef enum logic [1:0] {
      StOne   = 2'b00,
      StEmpty = 2'b01,
      StFull  = 2'b10
   } fifo2_state_e;

   // Wraps at an arbitrary depth, so non-power-of-two depths work.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_if
// Write/read handshake bundle of the synchronous FIFO.
//   wr_data/wr_en : push side, driven by the master
//   wr_full       : FIFO holds D entries
//   rd_data/rd_en : FWFT head and pop request
//   rd_empty      : FIFO holds no entries
//   count         : occupancy 0..D
// Modports: master (producer/consumer side), slave (the FIFO).
// -----------------------------------------------------------------------------
interface param_sync_fifo_if #(
   parameter int unsigned W = 8,
   parameter int unsigned D = 16
);
   logic [W-1:0]        wr_data;
   logic                wr_en;
   logic                wr_full;
   logic [W-1:0]        rd_data;
   logic                rd_en;
   logic                rd_empty;
   logic [$clog2(D):0]  count;

   modport master (
      output wr_data, wr_en, rd_en,
      input  wr_full, rd_data, rd_empty, count
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
      output wr_full, rd_data, rd_empty, count
   );
endinterface

// File: rtl/param_sync_fifo_2deep.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_2deep
// Two-entry FWFT FIFO core built from a head and a tail register.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   wr_data  : push data          wr_en    : push request
//   wr_full  : two entries held   rd_data  : head entry (FWFT)
//   rd_en    : pop request        rd_empty : no entries held
//   count    : occupancy, decoded from {wr_full, rd_empty}
// The head register always holds the oldest entry, so rd_data never
// depends combinationally on wr_data.
// -----------------------------------------------------------------------------
module param_sync_fifo_2deep
   import param_sync_fifo_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] wr_data,
   input  logic         wr_en,
   output logic         wr_full,
   output logic [W-1:0] rd_data,
   input  logic         rd_en,
   output logic         rd_empty,
   output logic [1:0]   count
);

   fifo2_state_e state_q, state_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Data registers are not reset; they are only meaningful while non-empty.
   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   // A push while full and a pop while empty are simply not decoded below.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         StEmpty: begin
            if (wr_en) begin
               head_d  = wr_data;
               state_d = StOne;
            end
         end
         StOne: begin
            case ({wr_en, rd_en})
               2'b10: begin
                  tail_d  = wr_data;
                  state_d = StFull;
               end
               2'b01:   state_d = StEmpty;
               2'b11:   head_d  = wr_data;
               default: ;
            endcase
         end
         StFull: begin
            if (rd_en) begin
               head_d  = tail_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      wr_full  = state_q[1];
      rd_empty = state_q[0];
      rd_data  = head_q;
      unique case ({wr_full, rd_empty})
         2'b00:   count = 2'd1;
         2'b01:   count = 2'd0;
         2'b10:   count = 2'd2;
         default: count = 2'd0;
      endcase
   end

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock first-word-fall-through FIFO, W bits wide and D entries deep.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; clears pointers, count and flags
//   bus   : slave side of param_sync_fifo_if (wr_data, wr_en, wr_full,
//           rd_data, rd_en, rd_empty, count)
// D == 2 uses the dedicated two-register core; every other depth uses a RAM
// array with wrapping read/write pointers and a registered occupancy count.
// -----------------------------------------------------------------------------
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int unsigned W  = 8,
   parameter int unsigned D  = 16,
   parameter int unsigned UB = $clog2(D)
) (
   input  logic          clk,
   input  logic          reset,
   param_sync_fifo_if.slave bus
);

   if (D == 2) begin : g_2deep
      logic [1:0] count2;

      param_sync_fifo_2deep #(
         .W (W)
      ) u_core (
         .clk      (clk),
         .reset    (reset),
         .wr_data  (bus.wr_data),
         .wr_en    (bus.wr_en),
         .wr_full  (bus.wr_full),
         .rd_data  (bus.rd_data),
         .rd_en    (bus.rd_en),
         .rd_empty (bus.rd_empty),
         .count    (count2)
      );

      assign bus.count = (UB+1)'(count2);
   end else begin : g_ram
      localparam int unsigned PW = $clog2(D);

      logic [W-1:0]  mem [D];
      logic [PW-1:0] wr_ptr_q, wr_ptr_d;
      logic [PW-1:0] rd_ptr_q, rd_ptr_d;
      logic [UB:0]   count_q, count_d;
      logic          full_q, full_d;
      logic          empty_q, empty_d;
      logic          push, pop;

      always_comb begin
         push     = bus.wr_en & ~full_q;
         pop      = bus.rd_en & ~empty_q;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (push) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), D));
         if (pop)  rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), D));
         case ({push, pop})
            2'b10:   count_d = count_q + (UB+1)'(1);
            2'b01:   count_d = count_q - (UB+1)'(1);
            default: ;
         endcase
         // Flags come from next count so they are registered alongside it.
         full_d  = (count_d == (UB+1)'(D));
         empty_d = (count_d == '0);
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
         end
      end

      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr_q] <= bus.wr_data;
      end

      assign bus.rd_data  = mem[rd_ptr_q];
      assign bus.wr_full  = full_q;
      assign bus.rd_empty = empty_q;
      assign bus.count    = count_q;
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   param_sync_fifo_if #(.W(8), .D(16)) b16 ();
   param_sync_fifo_if #(.W(8), .D(2))  b2 ();

   param_sync_fifo #(.W(8), .D(16)) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (b16)
   );

   param_sync_fifo #(.W(8), .D(2)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned viol16  = 0;
   int unsigned viol2   = 0;
   bit          chk_en  = 1'b0;

   // Reference model: each FIFO is an ordered queue with a size limit.
   logic [7:0] q16[$];
   logic [7:0] q2[$];
   bit         push16, pop16, push2, pop2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q16.delete();
         q2.delete();
      end else begin
         pop16  = b16.rd_en && (q16.size() != 0);
         push16 = b16.wr_en && (q16.size() != 16);
         if (b16.rd_en && q16.size() == 0) begin
            viol16++;
            $display("error: dut16 pop while empty @%0t (ignored)", $time);
         end
         if (b16.wr_en && q16.size() == 16) begin
            viol16++;
            $display("error: dut16 push while full @%0t (ignored)", $time);
         end
         if (pop16)  void'(q16.pop_front());
         if (push16) q16.push_back(b16.wr_data);

         pop2  = b2.rd_en && (q2.size() != 0);
         push2 = b2.wr_en && (q2.size() != 2);
         if (b2.rd_en && q2.size() == 0) begin
            viol2++;
            $display("error: dut2 pop while empty @%0t (ignored)", $time);
         end
         if (b2.wr_en && q2.size() == 2) begin
            viol2++;
            $display("error: dut2 push while full @%0t (ignored)", $time);
         end
         if (pop2)  void'(q2.pop_front());
         if (push2) q2.push_back(b2.wr_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cnt16",   b16.count,    q16.size());
         check("empty16", b16.rd_empty, (q16.size() == 0));
         check("full16",  b16.wr_full,  (q16.size() == 16));
         if (q16.size() != 0) check("data16", b16.rd_data, q16[0]);
         check("cnt2",    b2.count,     q2.size());
         check("empty2",  b2.rd_empty,  (q2.size() == 0));
         check("full2",   b2.wr_full,   (q2.size() == 2));
         if (q2.size() != 0) check("data2", b2.rd_data, q2[0]);
      end
   end

   task automatic cyc16(input logic we, input logic [7:0] wd, input logic re);
      b16.wr_en   = we;
      b16.wr_data = wd;
      b16.rd_en   = re;
      @(posedge clk);
      #1;
      b16.wr_en = 1'b0;
      b16.rd_en = 1'b0;
   endtask

   task automatic cyc2(input logic we, input logic [7:0] wd, input logic re);
      b2.wr_en   = we;
      b2.wr_data = wd;
      b2.rd_en   = re;
      @(posedge clk);
      #1;
      b2.wr_en = 1'b0;
      b2.rd_en = 1'b0;
   endtask

   initial begin
      b16.wr_en = 1'b0; b16.rd_en = 1'b0; b16.wr_data = 8'h00;
      b2.wr_en  = 1'b0; b2.rd_en  = 1'b0; b2.wr_data  = 8'h00;

      // Reset held for two cycles
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      chk_en = 1'b1;
      check("rst_cnt16",   b16.count,    0);
      check("rst_empty16", b16.rd_empty, 1);
      check("rst_full16",  b16.wr_full,  0);
      check("rst_cnt2",    b2.count,     0);
      check("rst_empty2",  b2.rd_empty,  1);
      check("rst_full2",   b2.wr_full,   0);

      // Fill and drain
      for (int i = 0; i < 16; i++) cyc16(1'b1, 8'(i), 1'b0);
      check("fill_cnt",  b16.count,   16);
      check("fill_full", b16.wr_full, 1);
      for (int i = 0; i < 16; i++) begin
         check("drain_data", b16.rd_data, i);
         cyc16(1'b0, 8'h00, 1'b1);
      end
      check("drain_cnt",   b16.count,    0);
      check("drain_empty", b16.rd_empty, 1);

      // Pop while empty is ignored
      cyc16(1'b0, 8'h00, 1'b1);
      check("illpop_cnt",   b16.count,    0);
      check("illpop_empty", b16.rd_empty, 1);

      // Wrap-around
      for (int i = 0; i < 10; i++) cyc16(1'b1, 8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 10; i++) cyc16(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 12; i++) cyc16(1'b1, 8'(8'hA0 + i), 1'b0);
      check("wrap_peak", b16.count, 12);
      for (int i = 0; i < 12; i++) begin
         check("wrap_data", b16.rd_data, 8'hA0 + i);
         cyc16(1'b0, 8'h00, 1'b1);
      end
      check("wrap_cnt", b16.count, 0);

      // Simultaneous push/pop at count 5
      for (int i = 0; i < 5; i++) cyc16(1'b1, 8'(8'h50 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         check("sim_cnt",  b16.count, 5);
         check("sim_data", b16.rd_data, (i < 5) ? (8'h50 + i) : (8'h60 + i - 5));
         cyc16(1'b1, 8'(8'h60 + i), 1'b1);
      end
      check("sim_cnt_end", b16.count, 5);
      for (int i = 0; i < 5; i++) begin
         check("sim_tail", b16.rd_data, 8'h6F + i);
         cyc16(1'b0, 8'h00, 1'b1);
      end

      // Push+pop while full drops the write
      for (int i = 0; i < 16; i++) cyc16(1'b1, 8'(8'hC0 + i), 1'b0);
      cyc16(1'b1, 8'hEE, 1'b1);
      check("fullpp_cnt",  b16.count,   15);
      check("fullpp_full", b16.wr_full, 0);
      cyc16(1'b1, 8'hEF, 1'b0);
      check("refill_cnt", b16.count, 16);
      cyc16(1'b1, 8'hFF, 1'b0);
      check("illpush_cnt",  b16.count,   16);
      check("illpush_head", b16.rd_data, 8'hC1);
      for (int i = 0; i < 16; i++) begin
         check("full_drain", b16.rd_data, (i < 15) ? (8'hC1 + i) : 8'hEF);
         cyc16(1'b0, 8'h00, 1'b1);
      end

      // Push+pop while empty only pushes
      cyc16(1'b1, 8'h77, 1'b1);
      check("emptypp_cnt",   b16.count,    1);
      check("emptypp_empty", b16.rd_empty, 0);
      check("emptypp_data",  b16.rd_data,  8'h77);
      cyc16(1'b0, 8'h00, 1'b1);
      check("emptypp_drain", b16.count, 0);
      check("viol16", viol16, 4);

      // Two-deep core
      cyc2(1'b1, 8'h11, 1'b0);
      check("d2_cnt1",  b2.count,   1);
      check("d2_data1", b2.rd_data, 8'h11);
      cyc2(1'b1, 8'h22, 1'b0);
      check("d2_full", b2.wr_full, 1);
      check("d2_cnt2", b2.count,   2);
      check("d2_head", b2.rd_data, 8'h11);
      cyc2(1'b0, 8'h00, 1'b1);
      check("d2_pop_cnt",  b2.count,   1);
      check("d2_pop_data", b2.rd_data, 8'h22);
      cyc2(1'b1, 8'h33, 1'b0);
      check("d2_cnt3", b2.count, 2);
      cyc2(1'b0, 8'h00, 1'b1);
      check("d2_data3", b2.rd_data, 8'h33);
      cyc2(1'b0, 8'h00, 1'b1);
      check("d2_cnt0",  b2.count,    0);
      check("d2_empty", b2.rd_empty, 1);
      cyc2(1'b1, 8'h44, 1'b0);
      cyc2(1'b1, 8'h55, 1'b1);
      check("d2_pp_cnt",  b2.count,   1);
      check("d2_pp_data", b2.rd_data, 8'h55);
      cyc2(1'b1, 8'h66, 1'b0);
      cyc2(1'b1, 8'h77, 1'b1);
      check("d2_fullpp_cnt",  b2.count,   1);
      check("d2_fullpp_data", b2.rd_data, 8'h66);
      cyc2(1'b0, 8'h00, 1'b1);
      check("d2_end_cnt", b2.count, 0);
      check("viol2", viol2, 1);

      // Asynchronous reset in the middle of a cycle
      for (int i = 0; i < 5; i++) cyc16(1'b1, 8'(8'h90 + i), 1'b0);
      cyc2(1'b1, 8'hAA, 1'b0);
      check("pre_rst_cnt16", b16.count, 5);
      #2 reset = 1'b0;
      #1;
      check("arst_cnt16",   b16.count,    0);
      check("arst_empty16", b16.rd_empty, 1);
      check("arst_full16",  b16.wr_full,  0);
      check("arst_cnt2",    b2.count,     0);
      check("arst_empty2",  b2.rd_empty,  1);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_cnt16", b16.count, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
